// File: rtl/debug_pkg.sv
// Shared definitions for the byte-stream debug port master: opcodes, FSM
// states and command field lengths.
package debug_pkg;

  localparam logic [7:0] OP_WR_IRAM = 8'h01;
  localparam logic [7:0] OP_WR_DRAM = 8'h02;
  localparam logic [7:0] OP_RD_IRAM = 8'h03;
  localparam logic [7:0] OP_RD_DRAM = 8'h04;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_BYTES = WORD_BYTES;
  localparam int DATA_BYTES = WORD_BYTES;
  localparam int RESP_BYTES = WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RWAIT = 3'd4,
    SEND  = 3'd5
  } state_e;

  function automatic logic op_legal(input logic [7:0] op);
    return (op >= OP_WR_IRAM) && (op <= OP_RD_DRAM);
  endfunction

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WR_IRAM) || (op == OP_WR_DRAM);
  endfunction

  function automatic logic op_is_dram(input logic [7:0] op);
    return (op == OP_WR_DRAM) || (op == OP_RD_DRAM);
  endfunction

endpackage

// File: rtl/debug_byte_packer.sv
// Assembles a 32-bit word from 4 bytes arriving LSB first; word_o already
// includes the byte being accepted so the caller can use it on the last beat.
module debug_byte_packer
  import debug_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [31:0] word_d;
  logic [1:0]  cnt_q;

  assign word_d = {byte_i, word_q[31:8]};
  assign word_o = shift_i ? word_d : word_q;
  assign last_o = shift_i && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else if (clr_i) begin
      cnt_q <= 2'd0;
    end else if (shift_i) begin
      word_q <= word_d;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/debug_port_master.sv
// Byte-stream command decoder driving the CPU instruction/data RAM debug
// ports: 1 opcode byte, 4 address bytes, 4 data bytes (writes), 4 reply bytes (reads).
module debug_port_master
  import debug_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  // rx/tx: a byte moves on a rising edge where valid && ready; the sender
  // keeps data stable while valid is high and ready is low.
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] iram_a2,
  output logic [31:0] iram_wd2,
  output logic [3:0]  iram_we2,
  input  logic [31:0] iram_rd2,
  output logic [31:0] dram_a2,
  output logic [31:0] dram_wd2,
  output logic [3:0]  dram_we2,
  input  logic [31:0] dram_rd2,
  output logic        busy,
  output logic        err,
  output state_e      dbg_state_o
);

  // RD_LATENCY must be at least 1; RWAIT counts down from this value.
  localparam logic [7:0] WAIT_INIT = 8'(RD_LATENCY - 1);

  state_e      state_q;
  logic        write_q;
  logic        dram_q;
  logic [7:0]  wait_q;
  logic [31:0] resp_q;
  logic [1:0]  send_cnt_q;
  logic [7:0]  tx_data_q;
  logic        err_q;
  logic [31:0] iram_a2_q, iram_wd2_q, dram_a2_q, dram_wd2_q;
  logic [3:0]  iram_we2_q, dram_we2_q;

  logic        rx_fire;
  logic        addr_shift, data_shift, pack_clr;
  logic [31:0] addr_word, data_word;
  logic        addr_last, data_last;
  logic [31:0] rd_word;

  assign rx_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q != IDLE);

  assign pack_clr   = rx_fire && (state_q == IDLE);
  assign addr_shift = rx_fire && (state_q == ADDR);
  assign data_shift = rx_fire && (state_q == DATA);
  assign rd_word    = dram_q ? dram_rd2 : iram_rd2;

  debug_byte_packer u_addr_packer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (pack_clr),
    .shift_i (addr_shift),
    .byte_i  (rx_data),
    .word_o  (addr_word),
    .last_o  (addr_last)
  );

  debug_byte_packer u_data_packer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (pack_clr),
    .shift_i (data_shift),
    .byte_i  (rx_data),
    .word_o  (data_word),
    .last_o  (data_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      dram_q     <= 1'b0;
      wait_q     <= 8'h0;
      resp_q     <= 32'h0;
      send_cnt_q <= 2'd0;
      tx_data_q  <= 8'h0;
      err_q      <= 1'b0;
      iram_a2_q  <= 32'h0;
      iram_wd2_q <= 32'h0;
      iram_we2_q <= 4'h0;
      dram_a2_q  <= 32'h0;
      dram_wd2_q <= 32'h0;
      dram_we2_q <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_fire) begin
            if (op_legal(rx_data)) begin
              write_q <= op_is_write(rx_data);
              dram_q  <= op_is_dram(rx_data);
              state_q <= ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (addr_last) begin
            if (write_q) begin
              state_q <= DATA;
            end else begin
              // Address goes out on the same edge RWAIT starts, so the
              // latency count begins with a stable a2.
              state_q <= RWAIT;
              wait_q  <= WAIT_INIT;
              if (dram_q) dram_a2_q <= addr_word;
              else        iram_a2_q <= addr_word;
            end
          end
        end
        DATA: begin
          if (data_last) begin
            state_q <= WRITE;
            if (dram_q) begin
              dram_a2_q  <= addr_word;
              dram_wd2_q <= data_word;
              dram_we2_q <= 4'hF;
            end else begin
              iram_a2_q  <= addr_word;
              iram_wd2_q <= data_word;
              iram_we2_q <= 4'hF;
            end
          end
        end
        WRITE: begin
          iram_we2_q <= 4'h0;
          dram_we2_q <= 4'h0;
          state_q    <= IDLE;
        end
        RWAIT: begin
          if (wait_q == 8'h0) begin
            tx_data_q  <= rd_word[7:0];
            resp_q     <= {8'h0, rd_word[31:8]};
            send_cnt_q <= 2'd0;
            state_q    <= SEND;
          end else begin
            wait_q <= wait_q - 8'h1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (send_cnt_q == 2'(RESP_BYTES - 1)) begin
              state_q <= IDLE;
            end else begin
              tx_data_q  <= resp_q[7:0];
              resp_q     <= {8'h0, resp_q[31:8]};
              send_cnt_q <= send_cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset kills an in-flight write strobe in the very cycle it is asserted.
  assign iram_we2    = rst ? 4'h0 : iram_we2_q;
  assign dram_we2    = rst ? 4'h0 : dram_we2_q;
  assign iram_a2     = iram_a2_q;
  assign iram_wd2    = iram_wd2_q;
  assign dram_a2     = dram_a2_q;
  assign dram_wd2    = dram_wd2_q;
  assign tx_data     = tx_data_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_debug_port_master.sv
// Self-checking bench for debug_port_master: RAM models, write/tx scoreboards
// and one task per scenario; a second instance covers RD_LATENCY=2.
module tb_debug_port_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [31:0] iram_a2, iram_wd2, iram_rd2, dram_a2, dram_wd2, dram_rd2;
  logic [3:0]  iram_we2, dram_we2;
  logic        busy, err;
  logic [2:0]  dbg_state;

  logic [7:0]  rx_data2, tx_data2;
  logic        rx_valid2, rx_ready2, tx_valid2, tx_ready2;
  logic [31:0] iram_a2_2, iram_wd2_2, iram_rd2_2, dram_a2_2, dram_wd2_2, dram_rd2_2;
  logic [3:0]  iram_we2_2, dram_we2_2;
  logic        busy2, err2;
  logic [2:0]  dbg_state2;

  int checks = 0;
  int failures = 0;
  logic [64:0] wr_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [64:0] mon_e, mon_got;
  logic [7:0]  mon_b;
  logic [31:0] iram_mem [0:255];
  logic [31:0] dram_mem [0:255];
  logic [31:0] cyc = 32'h0;

  debug_port_master #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
    .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
    .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  debug_port_master #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .iram_a2(iram_a2_2), .iram_wd2(iram_wd2_2), .iram_we2(iram_we2_2), .iram_rd2(iram_rd2_2),
    .dram_a2(dram_a2_2), .dram_wd2(dram_wd2_2), .dram_we2(dram_we2_2), .dram_rd2(dram_rd2_2),
    .busy(busy2), .err(err2), .dbg_state_o(dbg_state2)
  );

  // RAM models: write on the rising edge, read combinationally (latency 1 from a2).
  always @(posedge clk) begin
    cyc <= cyc + 32'h1;
    if (iram_we2 == 4'hF) iram_mem[iram_a2[7:0]] <= iram_wd2;
    if (dram_we2 == 4'hF) dram_mem[dram_a2[7:0]] <= dram_wd2;
  end
  assign iram_rd2   = iram_mem[iram_a2[7:0]];
  assign dram_rd2   = dram_mem[dram_a2[7:0]];
  // Latency-2 instance reads a free-running cycle count, exposing the sampling edge.
  assign iram_rd2_2 = cyc;
  assign dram_rd2_2 = 32'h0;

  always @(negedge clk) begin
    if (iram_we2 !== 4'h0 || dram_we2 !== 4'h0) begin
      checks++;
      if (wr_exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: iram_we2=%h dram_we2=%h, required no write strobe", iram_we2, dram_we2);
      end else begin
        mon_e   = wr_exp_q.pop_front();
        mon_got = (dram_we2 !== 4'h0) ? {1'b1, dram_a2, dram_wd2} : {1'b0, iram_a2, iram_wd2};
        if (mon_got !== mon_e || (iram_we2 !== 4'h0 && dram_we2 !== 4'h0) ||
            (iram_we2 !== 4'h0 && iram_we2 !== 4'hF) || (dram_we2 !== 4'h0 && dram_we2 !== 4'hF)) begin
          failures++;
          $display("FAIL wr_pulse: got dram=%0b a2=%h wd2=%h iwe=%h dwe=%h, required dram=%0b a2=%h wd2=%h we=F",
                   mon_got[64], mon_got[63:32], mon_got[31:0], iram_we2, dram_we2,
                   mon_e[64], mon_e[63:32], mon_e[31:0]);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      checks++;
      if (tx_exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected: tx_data=%h, required no byte", tx_data);
      end else begin
        mon_b = tx_exp_q.pop_front();
        if (tx_data !== mon_b) begin
          failures++;
          $display("FAIL tx_byte: got %h, required %h", tx_data, mon_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, output logic [31:0] c);
    int n;
    n = 0;
    if (sel) begin rx_data2 = b; rx_valid2 = 1'b1; end
    else     begin rx_data  = b; rx_valid  = 1'b1; end
    @(negedge clk);
    while (!(sel ? rx_ready2 : rx_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout: rx_ready low for %0d cycles, required accept", n);
    end
    c = cyc;
    tick();
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  task automatic send_cmd(input bit sel, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int max_gap, output logic [31:0] c);
    logic [7:0] bytes [9];
    int nb;
    bytes[0] = op;
    for (int i = 0; i < 4; i++) bytes[1+i] = addr[8*i +: 8];
    for (int i = 0; i < 4; i++) bytes[5+i] = data[8*i +: 8];
    nb = (op == 8'h01 || op == 8'h02) ? 9 : 5;
    for (int i = 0; i < nb; i++) begin
      send_byte(sel, bytes[i], c);
      if (max_gap > 0 && i < nb - 1) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((tx_exp_q.size() != 0 || busy || busy2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%0b tx_left=%0d, required idle", busy, tx_exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, tx_data, busy, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl: rx_ready=%0b tx_valid=%0b tx_data=%h busy=%0b err=%0b, required 1 0 00 0 0",
               rx_ready, tx_valid, tx_data, busy, err);
    end
    checks++;
    if ({iram_a2, iram_wd2, iram_we2, dram_a2, dram_wd2, dram_we2} !== 136'h0) begin
      failures++;
      $display("FAIL reset_ram: ia2=%h iwd=%h iwe=%h da2=%h dwd=%h dwe=%h, required all 0",
               iram_a2, iram_wd2, iram_we2, dram_a2, dram_wd2, dram_we2);
    end
    checks++;
    if (rx_ready2 !== 1'b1 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut2: rx_ready=%0b busy=%0b, required 1 0", rx_ready2, busy2);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_iram();
    logic [31:0] c;
    wr_exp_q.push_back({1'b0, 32'h0000_0010, 32'hDEAD_BEEF});
    send_cmd(1'b0, 8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 0, c);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b1 || iram_we2 !== 4'hF || dram_we2 !== 4'h0) begin
      failures++;
      $display("FAIL write_cycle: rx_ready=%0b busy=%0b iwe=%h dwe=%h, required 0 1 F 0",
               rx_ready, busy, iram_we2, dram_we2);
    end
    wait_idle();
    checks++;
    if (wr_exp_q.size() != 0) begin
      failures++;
      $display("FAIL write_iram_done: pending=%0d, required 0", wr_exp_q.size());
    end
  endtask

  task automatic test_read_dram();
    logic [31:0] c;
    int bad;
    bad = 0;
    push_rd(32'h1234_5678);
    send_cmd(1'b0, 8'h04, 32'h0000_0020, 32'h0, 0, c);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0 || dram_a2 !== 32'h20) begin
      failures++;
      $display("FAIL read_rwait: tx_valid=%0b rx_ready=%0b dram_a2=%h, required 0 0 00000020",
               tx_valid, rx_ready, dram_a2);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || tx_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL read_send_window: %0d bad cycles, required rx_ready=0 tx_valid=1 for 4 cycles", bad);
    end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_exp_q.size() != 0) begin
      failures++;
      $display("FAIL read_done: rx_ready=%0b tx_valid=%0b left=%0d, required 1 0 0",
               rx_ready, tx_valid, tx_exp_q.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] c;
    int n, bad;
    n = 0;
    bad = 0;
    tx_ready = 1'b0;
    push_rd(32'hDEAD_BEEF);
    send_cmd(1'b0, 8'h03, 32'h0000_0010, 32'h0, 0, c);
    @(negedge clk);
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      if (tx_data !== 8'hEF || tx_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || tx_exp_q.size() != 4) begin
      failures++;
      $display("FAIL bp_hold0: bad=%0d left=%0d tx_data=%h, required 0 4 EF", bad, tx_exp_q.size(), tx_data);
    end
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_data !== 8'hBE || tx_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || tx_exp_q.size() != 3) begin
      failures++;
      $display("FAIL bp_hold1: bad=%0d left=%0d tx_data=%h, required 0 3 BE", bad, tx_exp_q.size(), tx_data);
    end
    tick();
    tx_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_illegal();
    logic [31:0] c;
    send_byte(1'b0, 8'h07, c);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal_07: err=%0b busy=%0b rx_ready=%0b, required 1 0 1", err, busy, rx_ready);
    end
    tick();
    send_byte(1'b0, 8'h00, c);
    send_byte(1'b0, 8'hFF, c);
    wr_exp_q.push_back({1'b0, 32'hFFFF_FFFF, 32'h0123_4567});
    send_cmd(1'b0, 8'h01, 32'hFFFF_FFFF, 32'h0123_4567, 0, c);
    wait_idle();
    checks++;
    if (err !== 1'b1 || wr_exp_q.size() != 0) begin
      failures++;
      $display("FAIL illegal_then_write: err=%0b pending=%0d, required 1 0", err, wr_exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c;
    wr_exp_q.push_back({1'b1, 32'h0000_0003, 32'hA5A5_5A5A});
    send_cmd(1'b0, 8'h02, 32'h0000_0003, 32'hA5A5_5A5A, 3, c);
    push_rd(32'hA5A5_5A5A);
    send_cmd(1'b0, 8'h04, 32'h0000_0003, 32'h0, 2, c);
    push_rd(32'h0123_4567);
    send_cmd(1'b0, 8'h03, 32'hFFFF_FFFF, 32'h0, 0, c);
    wait_idle();
    checks++;
    if (wr_exp_q.size() != 0 || dram_a2 !== 32'h3 || iram_a2 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL back_to_back: pending=%0d dram_a2=%h iram_a2=%h, required 0 00000003 FFFFFFFF",
               wr_exp_q.size(), dram_a2, iram_a2);
    end
  endtask

  task automatic test_rst_abort();
    logic [31:0] c;
    send_byte(1'b0, 8'h01, c);
    send_byte(1'b0, 8'h44, c);
    send_byte(1'b0, 8'h00, c);
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1 || err !== 1'b0 || iram_a2 !== 32'h0) begin
      failures++;
      $display("FAIL rst_abort_state: busy=%0b rx_ready=%0b err=%0b ia2=%h, required 0 1 0 0",
               busy, rx_ready, err, iram_a2);
    end
    tick();
    rst = 1'b0;
    wr_exp_q.push_back({1'b0, 32'h0000_0044, 32'hCAFE_F00D});
    send_cmd(1'b0, 8'h01, 32'h0000_0044, 32'hCAFE_F00D, 0, c);
    push_rd(32'hCAFE_F00D);
    send_cmd(1'b0, 8'h03, 32'h0000_0044, 32'h0, 0, c);
    wait_idle();
    checks++;
    if (wr_exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_abort_rewrite: pending=%0d, required 0", wr_exp_q.size());
    end
  endtask

  task automatic test_rst_in_write();
    logic [31:0] c;
    send_cmd(1'b0, 8'h01, 32'h0000_0010, 32'h1111_1111, 0, c);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (iram_we2 !== 4'h0 || dram_we2 !== 4'h0) begin
      failures++;
      $display("FAIL rst_in_write: iwe=%h dwe=%h, required 0 0", iram_we2, dram_we2);
    end
    tick();
    rst = 1'b0;
    push_rd(32'hDEAD_BEEF);
    send_cmd(1'b0, 8'h03, 32'h0000_0010, 32'h0, 0, c);
    wait_idle();
  endtask

  task automatic test_latency2();
    logic [31:0] c0;
    logic [31:0] word;
    int nbytes, n;
    nbytes = 0;
    n = 0;
    word = 32'h0;
    send_cmd(1'b1, 8'h03, 32'h0000_0000, 32'h0, 0, c0);
    while (nbytes < 4 && n < 40) begin
      @(negedge clk);
      if (tx_valid2) begin
        word[8*nbytes +: 8] = tx_data2;
        nbytes++;
      end
      n++;
    end
    checks++;
    if (nbytes != 4 || word !== c0 + 32'd2) begin
      failures++;
      $display("FAIL latency2_sample: bytes=%0d word=%h, required 4 %h", nbytes, word, c0 + 32'd2);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      iram_mem[i] = 32'h0;
      dram_mem[i] = 32'h0;
    end
    dram_mem[8'h20] = 32'h1234_5678;
    rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b1;
    rx_data2 = 8'h0; rx_valid2 = 1'b0; tx_ready2 = 1'b1;

    test_reset();
    test_write_iram();
    test_read_dram();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_rst_abort();
    test_rst_in_write();
    test_latency2();

    checks++;
    if (wr_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: writes=%0d tx_bytes=%0d, required 0 0", wr_exp_q.size(), tx_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
